// File: rtl/regfile_cmd_pkg.sv
// Shared constants for the UART-driven register file command controller.
// Opcodes, default widths and FSM state encoding.
package regfile_cmd_pkg;

  localparam int WIDTH      = 8;
  localparam int ADDR_BITS  = 4;
  localparam int RD_TIMEOUT = 4;

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_EXEC = 3'd3,
    RD_ADDR = 3'd4,
    RD_EXEC = 3'd5,
    RD_WAIT = 3'd6,
    TX_HOLD = 3'd7
  } state_t;

endpackage

// File: rtl/regfile_cmd_ctrl.sv
// Byte-stream command parser driving register file write/read strobes
// and returning read data to the UART TX path over valid/ready.
module regfile_cmd_ctrl
  import regfile_cmd_pkg::*;
#(
  parameter int               WIDTH      = regfile_cmd_pkg::WIDTH,
  parameter int               ADDR_BITS  = regfile_cmd_pkg::ADDR_BITS,
  parameter logic [WIDTH-1:0] CMD_WR     = regfile_cmd_pkg::CMD_WR,
  parameter logic [WIDTH-1:0] CMD_RD     = regfile_cmd_pkg::CMD_RD,
  parameter int               RD_TIMEOUT = regfile_cmd_pkg::RD_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     rx_data,
  input  logic                 rx_valid,
  output logic [ADDR_BITS-1:0] rf_address,
  output logic                 rf_wr_en,
  output logic                 rf_rd_en,
  output logic [WIDTH-1:0]     rf_wr_data,
  input  logic [WIDTH-1:0]     rf_rd_data,
  input  logic                 rf_rd_valid,
  output logic [WIDTH-1:0]     tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 cmd_err
);

  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(RD_TIMEOUT - 1);

  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [ADDR_BITS-1:0] addr_d;
  logic [WIDTH-1:0]     wdata_d, txd_d;
  logic                 wr_d, rd_d, txv_d, err_d;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = rf_address;
    wdata_d = rf_wr_data;
    txd_d   = tx_data;
    txv_d   = tx_valid;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WR)
            state_d = WR_ADDR;
          else if (rx_data == CMD_RD)
            state_d = RD_ADDR;
          else
            err_d = 1'b1;
        end
      end
      WR_ADDR, RD_ADDR: begin
        if (rx_valid) begin
          addr_d = rx_data[ADDR_BITS-1:0];
          if (rx_data[WIDTH-1:ADDR_BITS] != '0) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (state == WR_ADDR) begin
            state_d = WR_DATA;
          end else begin
            state_d = RD_EXEC;
            rd_d    = 1'b1;
          end
        end
      end
      WR_DATA: begin
        if (rx_valid) begin
          wdata_d = rx_data;
          wr_d    = 1'b1;
          state_d = WR_EXEC;
        end
      end
      WR_EXEC: begin
        err_d   = rx_valid;
        state_d = IDLE;
      end
      RD_EXEC: begin
        err_d   = rx_valid;
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        err_d = rx_valid;
        if (rf_rd_valid) begin
          txd_d   = rf_rd_data;
          txv_d   = 1'b1;
          state_d = TX_HOLD;
        end else if (cnt >= TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      TX_HOLD: begin
        err_d = rx_valid;
        if (tx_ready) begin
          txv_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rf_address <= '0;
      rf_wr_data <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      rf_address <= addr_d;
      rf_wr_data <= wdata_d;
      rf_wr_en   <= wr_d;
      rf_rd_en   <= rd_d;
      tx_data    <= txd_d;
      tx_valid   <= txv_d;
      busy       <= (state_d != IDLE);
      cmd_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Self-checking bench for regfile_cmd_ctrl with a behavioural
// register file and an expected-contents model driven by the frames sent.
module tb_regfile_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] rf_address;
  logic       rf_wr_en;
  logic       rf_rd_en;
  logic [7:0] rf_wr_data;
  logic [7:0] rf_rd_data = 8'h00;
  logic       rf_rd_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       cmd_err;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] rf_mem  [16];
  logic [7:0] exp_mem [16];
  bit   resp_en = 1'b1;
  bit   spur    = 1'b0;
  logic prev_rd = 1'b0;

  regfile_cmd_ctrl dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rf_address(rf_address), .rf_wr_en(rf_wr_en),
    .rf_rd_en(rf_rd_en), .rf_wr_data(rf_wr_data),
    .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Register file slave: read data valid one cycle after rf_rd_en.
  always @(posedge clk) begin
    #1;
    rf_rd_valid = (prev_rd && resp_en) || spur;
    rf_rd_data  = (prev_rd && resp_en) ? rf_mem[rf_address] : 8'($urandom);
    prev_rd     = rf_rd_en;
    if (rf_wr_en === 1'b1) rf_mem[rf_address] = rf_wr_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    send(8'hAA);
    nvec++;
    if ({busy, rf_wr_en, cmd_err} !== 3'b100) begin
      nerr++;
      $display("FAIL wr_op: busy/wr/err=%b want 100", {busy, rf_wr_en, cmd_err});
    end
    send({4'h0, a});
    nvec++;
    if ({rf_wr_en, rf_rd_en, cmd_err} !== 3'b000) begin
      nerr++;
      $display("FAIL wr_addr: wr/rd/err=%b want 000", {rf_wr_en, rf_rd_en, cmd_err});
    end
    send(d);
    nvec++;
    if ({rf_wr_en, rf_rd_en, rf_address, rf_wr_data} !== {2'b10, a, d}) begin
      nerr++;
      $display("FAIL wr_exec: wr=%b rd=%b a=%h d=%h want 1 0 %h %h",
               rf_wr_en, rf_rd_en, rf_address, rf_wr_data, a, d);
    end
    exp_mem[a] = d;
    step();
    nvec++;
    if ({rf_wr_en, busy} !== 2'b00) begin
      nerr++;
      $display("FAIL wr_done: wr/busy=%b want 00", {rf_wr_en, busy});
    end
  endtask

  task automatic do_read(input logic [3:0] a, input int hold, input bit early);
    send(8'hBB);
    send({4'h0, a});
    nvec++;
    if ({rf_rd_en, rf_wr_en, rf_address, tx_valid} !== {2'b10, a, 1'b0}) begin
      nerr++;
      $display("FAIL rd_exec: rd=%b wr=%b a=%h txv=%b want 1 0 %h 0",
               rf_rd_en, rf_wr_en, rf_address, tx_valid, a);
    end
    step();
    nvec++;
    if ({rf_rd_en, tx_valid, busy} !== 3'b001) begin
      nerr++;
      $display("FAIL rd_wait: rd/txv/busy=%b want 001", {rf_rd_en, tx_valid, busy});
    end
    if (early) tx_ready = 1'b1;
    step();
    nvec++;
    if ({tx_valid, tx_data} !== {1'b1, exp_mem[a]}) begin
      nerr++;
      $display("FAIL rd_tx: txv=%b data=%h want 1 %h", tx_valid, tx_data, exp_mem[a]);
    end
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        step();
        nvec++;
        if ({tx_valid, tx_data, busy} !== {1'b1, exp_mem[a], 1'b1}) begin
          nerr++;
          $display("FAIL rd_hold: txv=%b data=%h busy=%b want 1 %h 1",
                   tx_valid, tx_data, busy, exp_mem[a]);
        end
      end
      tx_ready = 1'b1;
    end
    step();
    tx_ready = 1'b0;
    nvec++;
    if ({tx_valid, busy, cmd_err} !== 3'b000) begin
      nerr++;
      $display("FAIL rd_done: txv/busy/err=%b want 000", {tx_valid, busy, cmd_err});
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    tx_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      nvec++;
      if ({rf_address, rf_wr_en, rf_rd_en, rf_wr_data, tx_data,
           tx_valid, busy, cmd_err} !== 25'd0) begin
        nerr++;
        $display("FAIL reset: outputs=%h want 0", {rf_address, rf_wr_en,
                 rf_rd_en, rf_wr_data, tx_data, tx_valid, busy, cmd_err});
      end
    end
    rx_valid = 1'b0;
    rst      = 1'b0;
    step();
    nvec++;
    if ({rf_wr_en, rf_rd_en, busy, cmd_err, tx_valid} !== 5'd0) begin
      nerr++;
      $display("FAIL reset_rel: wr/rd/busy/err/txv=%b want 0",
               {rf_wr_en, rf_rd_en, busy, cmd_err, tx_valid});
    end
  endtask

  task automatic test_write();
    do_write(4'h3, 8'h5C);
  endtask

  task automatic test_read();
    rf_mem[2]  = 8'h81;
    exp_mem[2] = 8'h81;
    do_read(4'h2, 3, 1'b0);
    do_read(4'h3, 0, 1'b1);
  endtask

  task automatic test_errors();
    send(8'h5A);
    nvec++;
    if ({cmd_err, busy, rf_wr_en, rf_rd_en} !== 4'b1000) begin
      nerr++;
      $display("FAIL err_op: err/busy/wr/rd=%b want 1000",
               {cmd_err, busy, rf_wr_en, rf_rd_en});
    end
    step();
    nvec++;
    if (cmd_err !== 1'b0) begin
      nerr++;
      $display("FAIL err_pulse: err=%b want 0", cmd_err);
    end
    send(8'hBB);
    send(8'h13);
    nvec++;
    if ({cmd_err, rf_rd_en, busy} !== 3'b100) begin
      nerr++;
      $display("FAIL err_rdaddr: err/rd/busy=%b want 100", {cmd_err, rf_rd_en, busy});
    end
    step();
    nvec++;
    if ({rf_rd_en, cmd_err} !== 2'b00) begin
      nerr++;
      $display("FAIL err_rdaddr2: rd/err=%b want 00", {rf_rd_en, cmd_err});
    end
    send(8'hAA);
    send(8'hF0);
    nvec++;
    if ({cmd_err, rf_wr_en, busy} !== 3'b100) begin
      nerr++;
      $display("FAIL err_wraddr: err/wr/busy=%b want 100", {cmd_err, rf_wr_en, busy});
    end
    spur = 1'b1;
    step();
    step();
    spur = 1'b0;
    step();
    nvec++;
    if ({busy, tx_valid, cmd_err} !== 3'b000) begin
      nerr++;
      $display("FAIL spur_valid: busy/txv/err=%b want 000", {busy, tx_valid, cmd_err});
    end
    send(8'hBB);
    send(8'h06);
    step();
    step();
    send(8'($urandom));
    nvec++;
    if ({cmd_err, tx_valid, busy, tx_data} !== {3'b111, exp_mem[6]}) begin
      nerr++;
      $display("FAIL err_txhold: err=%b txv=%b busy=%b data=%h want 1 1 1 %h",
               cmd_err, tx_valid, busy, tx_data, exp_mem[6]);
    end
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    nvec++;
    if ({tx_valid, cmd_err, busy} !== 3'b000) begin
      nerr++;
      $display("FAIL err_txdone: txv/err/busy=%b want 000", {tx_valid, cmd_err, busy});
    end
  endtask

  task automatic test_timeout();
    resp_en = 1'b0;
    send(8'hBB);
    send(8'h01);
    nvec++;
    if (rf_rd_en !== 1'b1) begin
      nerr++;
      $display("FAIL to_rd: rd=%b want 1", rf_rd_en);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      nvec++;
      if ({cmd_err, tx_valid, busy} !== 3'b001) begin
        nerr++;
        $display("FAIL to_wait%0d: err/txv/busy=%b want 001", i, {cmd_err, tx_valid, busy});
      end
    end
    step();
    nvec++;
    if ({cmd_err, tx_valid, busy} !== 3'b100) begin
      nerr++;
      $display("FAIL to_err: err/txv/busy=%b want 100", {cmd_err, tx_valid, busy});
    end
    step();
    nvec++;
    if ({cmd_err, tx_valid} !== 2'b00) begin
      nerr++;
      $display("FAIL to_after: err/txv=%b want 00", {cmd_err, tx_valid});
    end
    resp_en = 1'b1;
  endtask

  task automatic test_reset_midop();
    send(8'hBB);
    send(8'h0A);
    step();
    step();
    nvec++;
    if (tx_valid !== 1'b1) begin
      nerr++;
      $display("FAIL rm_hold: txv=%b want 1", tx_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    nvec++;
    if ({tx_valid, busy, rf_address, tx_data} !== 14'd0) begin
      nerr++;
      $display("FAIL rm_reset: txv=%b busy=%b a=%h data=%h want 0",
               tx_valid, busy, rf_address, tx_data);
    end
    do_write(4'hF, 8'hFF);
    send(8'hAA);
    send(8'h05);
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    rst      = 1'b1;
    step();
    rx_valid = 1'b0;
    rst      = 1'b0;
    nvec++;
    if ({rf_wr_en, busy, rf_wr_data} !== 10'd0) begin
      nerr++;
      $display("FAIL rm_wr: wr=%b busy=%b d=%h want 0", rf_wr_en, busy, rf_wr_data);
    end
    step();
    do_read(4'h5, 1, 1'b0);
    do_read(4'hF, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] a;
    logic [7:0] d;
    a = 4'($urandom);
    d = 8'($urandom);
    do_write(a, d);
    do_read(a, 0, 1'b0);
    do_write(a + 4'h1, ~d);
    do_write(a, d ^ 8'h5A);
    do_read(a + 4'h1, 1, 1'b1);
    do_read(a, 2, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: do_write(4'($urandom), 8'($urandom));
        1: do_read(4'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        2: begin
          do b = 8'($urandom); while (b == 8'hAA || b == 8'hBB);
          send(b);
          nvec++;
          if ({cmd_err, busy} !== 2'b10) begin
            nerr++;
            $display("FAIL rnd_op %h: err/busy=%b want 10", b, {cmd_err, busy});
          end
        end
        default: begin
          send($urandom_range(0, 1) ? 8'hAA : 8'hBB);
          b = {4'($urandom_range(1, 15)), 4'($urandom)};
          send(b);
          nvec++;
          if ({cmd_err, busy, rf_wr_en, rf_rd_en} !== 4'b1000) begin
            nerr++;
            $display("FAIL rnd_addr %h: err/busy/wr/rd=%b want 1000",
                     b, {cmd_err, busy, rf_wr_en, rf_rd_en});
          end
        end
      endcase
    end
    for (int i = 0; i < 16; i++) do_read(4'(i), 0, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rf_mem[i]  = 8'($urandom);
      exp_mem[i] = rf_mem[i];
    end
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_timeout();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
